// File: rtl/itcm_boot_loader.sv
// Streams a byte image into the ITCM through a request/grant write port and holds the core in reset until loaded.
// Optional `ITCM_LOADER_ZERO_FILL_EN`: zero-fill the remaining ITCM words after the image.
module itcm_boot_loader #(
    parameter int DW = 32,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          swap,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          ram_req,
    input  logic          ram_gnt,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdat,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt,
    output logic          core_rst_n
);

    localparam int NB = DW / 8;
    localparam int IW = $clog2(NB + 1);
    localparam logic [AW-1:0] ADDR_MAX = '1;

`ifdef ITCM_LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, FILL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic            swap_q;
    logic            last_q;
    logic            ovf_q;
    logic            err_q;
    logic [IW-1:0]   idx_q;
    logic [AW-1:0]   addr_q;
    logic [AW:0]     cnt_q;
    logic [DW-1:0]   asm_q;

    logic [IW-1:0]   idx_inc;
    logic [IW-1:0]   lane;
    logic            word_full;
    logic            at_max;

    assign idx_inc   = idx_q + 1'b1;
    assign word_full = (idx_inc == IW'(NB));
    assign lane      = swap_q ? (IW'(NB - 1) - idx_q) : idx_q;
    assign at_max    = (addr_q == ADDR_MAX);

    // All outputs decode straight from registered state; no input reaches an output combinationally.
    assign s_ready    = (state_q == LOAD);
`ifdef ITCM_LOADER_ZERO_FILL_EN
    assign ram_req    = (state_q == WRITE) || (state_q == FILL);
`else
    assign ram_req    = (state_q == WRITE);
`endif
    assign busy       = s_ready || ram_req;
    assign done       = (state_q == DONE);
    assign core_rst_n = done;
    assign ram_addr   = addr_q;
    assign ram_wdat   = asm_q;
    assign err        = err_q;
    assign word_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (s_valid) begin
                    if (ovf_q) begin
                        if (s_last) state_d = DONE;
                    end else if (s_last || word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (ram_gnt) begin
                    if (!last_q) begin
                        state_d = LOAD;
                    end else begin
`ifdef ITCM_LOADER_ZERO_FILL_EN
                        // An image that ends exactly at full depth has nothing left to fill.
                        state_d = at_max ? DONE : FILL;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef ITCM_LOADER_ZERO_FILL_EN
            FILL: begin
                if (ram_gnt && at_max) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_q <= 1'b0;
            last_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            idx_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            asm_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        swap_q <= swap;
                        last_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        err_q  <= 1'b0;
                        idx_q  <= '0;
                        addr_q <= '0;
                        cnt_q  <= '0;
                        asm_q  <= '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (ovf_q) begin
                            // Past the last slot: swallow bytes, flag the overrun when the image ends.
                            if (s_last) err_q <= 1'b1;
                        end else begin
                            for (int i = 0; i < NB; i++) begin
                                if (lane == IW'(i)) asm_q[i*8 +: 8] <= s_data;
                            end
                            idx_q  <= idx_inc;
                            last_q <= s_last;
                        end
                    end
                end
                WRITE: begin
                    if (ram_gnt) begin
                        cnt_q <= cnt_q + 1'b1;
                        asm_q <= '0;
                        idx_q <= '0;
                        if (at_max) begin
                            ovf_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
`ifdef ITCM_LOADER_ZERO_FILL_EN
                FILL: begin
                    if (ram_gnt && !at_max) addr_q <= addr_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Self-checking bench for itcm_boot_loader (DW=32, AW=4): table vectors, hand corner sequences, randomized loads vs. a model.
module tb_itcm_boot_loader;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          swap = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          ram_req;
    logic          ram_gnt;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;
    logic          core_rst_n;

    logic gnt_rand_en = 1'b0;
    logic gnt_man     = 1'b1;
    logic gnt_rnd     = 1'b1;
    assign ram_gnt = gnt_rand_en ? gnt_rnd : gnt_man;

    itcm_boot_loader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .swap(swap),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt), .core_rst_n(core_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        gnt_rnd = 1'($urandom_range(0, 1));
    end

    // Write monitor: inputs change just after posedge, so a negedge sample shows what the next edge commits.
    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];
    always @(negedge clk) begin
        if (rst_n && ram_req && ram_gnt) begin
            mon_addr.push_back(ram_addr);
            mon_data.push_back(ram_wdat);
        end
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]    img_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_err;
    int            exp_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_core_rst_n"}, core_rst_n, 0);
        check({name, "_ram_req"},    ram_req,    0);
        check({name, "_ram_addr"},   ram_addr,   0);
        check({name, "_ram_wdat"},   ram_wdat,   0);
        check({name, "_busy"},       busy,       0);
        check({name, "_done"},       done,       0);
        check({name, "_err"},        err,        0);
        check({name, "_word_cnt"},   word_cnt,   0);
        check({name, "_s_ready"},    s_ready,    0);
    endtask

    task automatic add_fill(input int nw);
`ifdef ITCM_LOADER_ZERO_FILL_EN
        for (int a = nw; a < DEPTH; a++) begin
            exp_addr.push_back(AW'(a));
            exp_data.push_back('0);
        end
`else
        if (nw < 0) $display("unreachable");
`endif
    endtask

    // Reference: byte k goes to word k/NB at lane k%NB (or mirrored); only DEPTH words fit.
    task automatic build_model(input bit sw);
        int n;
        int nw;
        logic [DW-1:0] word;
        n  = img_q.size();
        nw = (n + NB - 1) / NB;
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < nw && w < DEPTH; w++) begin
            word = '0;
            for (int b = 0; b < NB; b++) begin
                int k;
                int ln;
                k  = w * NB + b;
                ln = sw ? NB - 1 - b : b;
                if (k < n) word[ln*8 +: 8] = img_q[k];
            end
            exp_addr.push_back(AW'(w));
            exp_data.push_back(word);
        end
        exp_err = (nw > DEPTH);
        exp_cnt = exp_err ? DEPTH : nw;
        if (!exp_err) add_fill(nw);
    endtask

    task automatic random_image(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back(8'($urandom));
    endtask

    task automatic do_start(input bit sw);
        mon_addr.delete();
        mon_data.delete();
        start = 1'b1;
        swap  = sw;
        @(posedge clk); #1;
        start = 1'b0;
        swap  = ~sw;
    endtask

    task automatic feed_bytes(input int count, input bit gaps, input bit poke);
        for (int i = 0; i < count; i++) begin
            int  t;
            bit  rdy;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_last  = 1'($urandom_range(0, 1));
                    s_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = img_q[i];
            s_last  = (i == img_q.size() - 1);
            if (poke && i == 2 && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                swap  = ~swap;
            end
            t   = 0;
            rdy = 1'b0;
            while (!rdy && t < 200) begin
                @(negedge clk);
                rdy = s_ready;
                @(posedge clk); #1;
                start = 1'b0;
                t++;
            end
            if (!rdy) begin
                timeout("byte_accept");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!done) timeout({name, "_done"});
    endtask

    task automatic compare_result(input string name);
        int m;
        check({name, "_nwrites"}, mon_addr.size(), exp_addr.size());
        m = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_addr%0d", name, i), mon_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", name, i), mon_data[i], exp_data[i]);
        end
        check({name, "_done"},       done,       1);
        check({name, "_core_rst_n"}, core_rst_n, 1);
        check({name, "_busy"},       busy,       0);
        check({name, "_err"},        err,        exp_err);
        check({name, "_word_cnt"},   word_cnt,   exp_cnt);
    endtask

    typedef struct {
        bit          sw;
        int          n;
        logic [63:0] bytes;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sw: 1'b0, n: 4, bytes: 64'h13000093,         nw: 1, w0: 32'h13000093, w1: 32'h0};
        vecs[1] = '{sw: 1'b1, n: 4, bytes: 64'h13000093,         nw: 1, w0: 32'h93000013, w1: 32'h0};
        vecs[2] = '{sw: 1'b0, n: 6, bytes: 64'h060504030201,     nw: 2, w0: 32'h04030201, w1: 32'h00000605};
        vecs[3] = '{sw: 1'b0, n: 8, bytes: 64'h0807060504030201, nw: 2, w0: 32'h04030201, w1: 32'h08070605};
        vecs[4] = '{sw: 1'b1, n: 6, bytes: 64'h060504030201,     nw: 2, w0: 32'h01020304, w1: 32'h05060000};
        vecs[5] = '{sw: 1'b1, n: 1, bytes: 64'hAA,               nw: 1, w0: 32'hAA000000, w1: 32'h0};
        vecs[6] = '{sw: 1'b0, n: 1, bytes: 64'hAA,               nw: 1, w0: 32'h000000AA, w1: 32'h0};

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors, grant tied high
        for (int v = 0; v < 7; v++) begin
            img_q.delete();
            for (int i = 0; i < vecs[v].n; i++) img_q.push_back(vecs[v].bytes[i*8 +: 8]);
            exp_addr.delete();
            exp_data.delete();
            exp_addr.push_back(AW'(0));
            exp_data.push_back(vecs[v].w0);
            if (vecs[v].nw == 2) begin
                exp_addr.push_back(AW'(1));
                exp_data.push_back(vecs[v].w1);
            end
            exp_err = 1'b0;
            exp_cnt = vecs[v].nw;
            add_fill(vecs[v].nw);
            do_start(vecs[v].sw);
            feed_bytes(vecs[v].n, 1'b0, 1'b0);
            wait_done($sformatf("vec%0d", v));
            compare_result($sformatf("vec%0d", v));
        end

        // Overflow: 68 bytes, and exact full depth (64 bytes, no error, no fill)
        random_image(68);
        build_model(1'b0);
        do_start(1'b0);
        feed_bytes(68, 1'b0, 1'b0);
        wait_done("ovf68");
        compare_result("ovf68");

        random_image(64);
        build_model(1'b1);
        do_start(1'b1);
        feed_bytes(64, 1'b0, 1'b0);
        wait_done("full64");
        compare_result("full64");

        // Grant stall in WRITE
        gnt_man = 1'b0;
        img_q.delete();
        img_q.push_back(8'h11); img_q.push_back(8'h22);
        img_q.push_back(8'h33); img_q.push_back(8'h44);
        build_model(1'b0);
        do_start(1'b0);
        feed_bytes(4, 1'b0, 1'b0);
        check("stall_req_n1", ram_req, 1);
        check("stall_ready_n1", s_ready, 0);
        check("stall_addr_n1", ram_addr, 0);
        check("stall_wdat_n1", ram_wdat, 32'h44332211);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall_req_c%0d", c), ram_req, 1);
            check($sformatf("stall_ready_c%0d", c), s_ready, 0);
            check($sformatf("stall_addr_c%0d", c), ram_addr, 0);
            check($sformatf("stall_wdat_c%0d", c), ram_wdat, 32'h44332211);
        end
        check("stall_nowrite", mon_addr.size(), 0);
        gnt_man = 1'b1;
        @(posedge clk); #1;
`ifdef ITCM_LOADER_ZERO_FILL_EN
        check("stall_fill_req", ram_req, 1);
        check("stall_fill_addr", ram_addr, 1);
`else
        check("stall_done_next", done, 1);
        check("stall_core_rst_next", core_rst_n, 1);
`endif
        wait_done("stall");
        compare_result("stall");

        // Reset mid-load after 5 bytes
        random_image(8);
        do_start(1'b1);
        feed_bytes(5, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst_prewrites", mon_addr.size(), 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_hold_req", ram_req, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        random_image(9);
        build_model(1'b0);
        do_start(1'b0);
        feed_bytes(9, 1'b0, 1'b0);
        wait_done("reload");
        compare_result("reload");

        // Randomized loads: random length, gaps, stray s_last, random grant, start while busy
        gnt_rand_en = 1'b1;
        for (int r = 0; r < 20; r++) begin
            bit sw;
            sw = 1'($urandom_range(0, 1));
            random_image($urandom_range(1, 70));
            build_model(sw);
            do_start(sw);
            feed_bytes(img_q.size(), 1'b1, 1'b1);
            wait_done($sformatf("rnd%0d", r));
            compare_result($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
